time_keeper_core: RTL and testbench
===================================

Name: time_keeper_core

Overview:
Timekeeping datapath directly downstream of the switch/mode selector stage. It consumes `mode` and the six active-low adjust requests `operator[5:0]`, and keeps a 24-hour HH:MM:SS time in BCD. In run mode the time advances from a clock prescaler. In edit mode the time is frozen and each debounced press steps its own field up or down. The outputs feed the 7-segment display encoder.

Parameters:
CLK_HZ, 50000000, clk cycles per 1-second tick (prescaler terminal count = CLK_HZ-1)
DEB_CYCLES, 500000, consecutive stable synchronised cycles required to accept a button level change

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
mode  input  1  1 = edit (time frozen, adjust enabled); 0 = run
operator  input  6  active-low raw requests: [0] sec+, [1] sec-, [2] min+, [3] min-, [4] hr+, [5] hr-; idle = 6'b111111
hour_bcd  output  8  hours, BCD {tens,units}, 00..23
min_bcd  output  8  minutes, BCD, 00..59
sec_bcd  output  8  seconds, BCD, 00..59
sec_tick  output  1  one-cycle pulse on each run-mode second advance
edit_active  output  1  registered copy of mode

Behaviour:
- Reset (rst_n low, asynchronous):
  - hour/min/sec = 00:00:00; prescaler = 0.
  - sec_tick = 0; edit_active = 0.
  - All synchronisers and debouncers = released (1); stability counters = 0.
  - Release is sampled on clk; the first prescaler count happens on the first clk edge with rst_n high.
- Input conditioning, per operator bit and for mode:
  - 2-FF synchroniser.
  - Debouncer, operator bits only: the debounced level changes only after the synchronised level differs from it for DEB_CYCLES consecutive cycles. Any mismatch-free cycle clears the counter.
  - Press pulse = one-cycle strobe on a debounced 1->0 transition. Release generates nothing.
  - One press yields exactly one step regardless of hold length; there is no auto-repeat.
- Run mode (synchronised mode = 0):
  - Prescaler counts 0..CLK_HZ-1 and wraps.
  - At terminal count: sec_tick = 1 for that cycle, and time += 1 s on the same edge.
  - Carry chain: sec 59->00 carries to min; min 59->00 carries to hr; hr 23->00.
  - Press pulses are discarded. Debouncers keep tracking.
- Edit mode (synchronised mode = 1):
  - Prescaler held at 0; sec_tick = 0; no time advance.
  - sec+/sec-: sec mod 60. min+/min-: min mod 60. hr+/hr-: hr mod 24.
  - No carry or borrow across fields: sec 59 +1 -> 00 with min unchanged; 00 -1 -> 59.
  - + and - pulses for the same field in the same cycle: field unchanged.
  - Pulses for different fields in the same cycle: each applied independently.
  - A field updates on the clk edge after its press pulse.
- Mode transitions:
  - 1->0: prescaler restarts at 0, so the first tick comes CLK_HZ cycles later. A press pulse coincident with the switch is dropped.
  - 0->1: a pending tick on that same edge still completes.
- Arithmetic:
  - All registers held in BCD.
  - Units digit 9 rolls to 0 with tens+1.
  - Decrement of units 0 gives 9 with tens-1.
  - Limits are checked on the full field (59 / 23) before digit arithmetic.
  - Illegal BCD never appears on the outputs.
- Latency: raw operator falling edge to field change = 2 (sync) + DEB_CYCLES + 2 cycles, assuming the input is held stable.
- Outputs: all registered; no combinational path from any input.

Test Plan:
Use CLK_HZ=10 and DEB_CYCLES=3 for all scenarios.
1. Reset, mode=0, operator=111111, run 10 cycles -> exactly one sec_tick; sec_bcd=8'h01, min/hr 00; after 600 cycles from reset -> 00:01:00.
2. Edit the time to 23:59:59 (via presses), set mode=0, run 10 cycles -> one sec_tick; time 00:00:00; all carries propagate on the same edge.
3. mode=1 at 00:00:00: press operator[1] -> sec 8'h59, min 00. Press operator[5] -> hr 8'h23. Press operator[2] sixty times -> min returns to 00 and hr stays 23.
4. Bounce: operator[0] low for 2 cycles then high -> no change. Low for 5 cycles -> sec +1 exactly once. Held low for 100 cycles -> still only +1.
5. Simultaneous operator[0] and operator[1] low -> sec unchanged. Simultaneous operator[0] and operator[2] low -> sec+1 and min+1. mode=0 with operator[0] pulsed -> no change.
6. Assert rst_n low mid-run at 12:34:56 with a press in progress -> outputs 00:00:00 immediately (asynchronously), sec_tick 0; after release, no spurious step from the held button until it is released and pressed again.

Source files
------------

// File: rtl/time_keeper_core.sv
// Purpose: 24h BCD time-of-day keeper with a run-mode prescaler and an edit mode driven by debounced step buttons.
// Latency: registered outputs; tick to time update on the same edge; raw press to field change 2 + DEB_CYCLES + 2 cycles.
// Backpressure: none; free-running block. Presses arriving in run mode are discarded, never queued.
//
// Ports: clk, rst_n (async active-low); mode (1 = edit, 0 = run);
//        operator[5:0] active-low step requests {hr-, hr+, min-, min+, sec-, sec+};
//        hour_bcd/min_bcd/sec_bcd BCD time; sec_tick one-cycle second strobe; edit_active synchronised mode.
module time_keeper_core #(
    parameter int CLK_HZ     = 50000000,
    parameter int DEB_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode,
    input  logic [5:0] operator,
    output logic [7:0] hour_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       sec_tick,
    output logic       edit_active
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(CLK_HZ - 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEB_CYCLES - 1);

    logic          mode_s1, mode_s2;
    logic [5:0]    op_s1, op_s2;
    logic [5:0]    deb;
    logic [5:0]    deb_d;
    logic [5:0]    press;
    logic [DW-1:0] db_cnt [6];
    logic [PW-1:0] presc, presc_n;
    logic [7:0]    hr_n, min_n, sec_n;
    logic          tick_n;

    // Limit is tested on the whole field first, so digit arithmetic never sees 59/23.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
        if (v == lim)            return 8'h00;
        else if (v[3:0] == 4'h9) return {v[7:4] + 4'd1, 4'h0};
        else                     return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] lim);
        if (v == 8'h00)          return lim;
        else if (v[3:0] == 4'h0) return {v[7:4] - 4'd1, 4'h9};
        else                     return {v[7:4], v[3:0] - 4'd1};
    endfunction

    // Opposing requests for the same field cancel out.
    function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic up, input logic dn,
                                            input logic [7:0] lim);
        if (up && !dn)      return bcd_inc(v, lim);
        else if (dn && !up) return bcd_dec(v, lim);
        else                return v;
    endfunction

    // Synchronisers, debouncers and press strobes. The press strobe is registered
    // so it lines up one cycle after the debounced level settles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_s1 <= 1'b0;
            mode_s2 <= 1'b0;
            op_s1   <= '1;
            op_s2   <= '1;
            deb     <= '1;
            deb_d   <= '1;
            press   <= '0;
            for (int i = 0; i < 6; i++) db_cnt[i] <= '0;
        end else begin
            mode_s1 <= mode;
            mode_s2 <= mode_s1;
            op_s1   <= operator;
            op_s2   <= op_s1;
            deb_d   <= deb;
            press   <= deb_d & ~deb;
            for (int i = 0; i < 6; i++) begin
                if (op_s2[i] != deb[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        deb[i]    <= op_s2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DW'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Run mode counts and carries; edit mode freezes the prescaler at 0 and
    // applies each field's strobes independently without carry or borrow.
    always_comb begin
        presc_n = presc;
        tick_n  = 1'b0;
        hr_n    = hour_bcd;
        min_n   = min_bcd;
        sec_n   = sec_bcd;
        if (!mode_s2) begin
            if (presc == PS_LAST) begin
                presc_n = '0;
                tick_n  = 1'b1;
                sec_n   = bcd_inc(sec_bcd, 8'h59);
                if (sec_bcd == 8'h59) begin
                    min_n = bcd_inc(min_bcd, 8'h59);
                    if (min_bcd == 8'h59) hr_n = bcd_inc(hour_bcd, 8'h23);
                end
            end else begin
                presc_n = presc + PW'(1);
            end
        end else begin
            presc_n = '0;
            sec_n   = bcd_step(sec_bcd,  press[0], press[1], 8'h59);
            min_n   = bcd_step(min_bcd,  press[2], press[3], 8'h59);
            hr_n    = bcd_step(hour_bcd, press[4], press[5], 8'h23);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc    <= '0;
            sec_tick <= 1'b0;
            hour_bcd <= 8'h00;
            min_bcd  <= 8'h00;
            sec_bcd  <= 8'h00;
        end else begin
            presc    <= presc_n;
            sec_tick <= tick_n;
            hour_bcd <= hr_n;
            min_bcd  <= min_n;
            sec_bcd  <= sec_n;
        end
    end

    // The synchroniser's second stage is already a flop and is exactly the mode in force.
    assign edit_active = mode_s2;

endmodule

// File: tb/tb_time_keeper_core.sv
// Purpose: self-checking bench for time_keeper_core against an event-level reference model.
// Latency: model predicts outputs every cycle; directed checks sampled 1 time unit after the falling clock edge.
// Backpressure: not applicable; stimulus is free-running.
module tb_time_keeper_core;

    localparam int CLK_HZ = 10;
    localparam int DEB    = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode = 1'b0;
    logic [5:0] operator = 6'h3f;
    logic [7:0] hour_bcd, min_bcd, sec_bcd;
    logic       sec_tick, edit_active;

    int checks = 0;
    int failures = 0;
    int tick_cnt = 0;

    // Reference model state: plain integers for the time, a per-button count of
    // consecutive raw samples disagreeing with the accepted level, and the edge
    // number at which an accepted press should land.
    int mh = 0, mm = 0, ms = 0, mpc = 0, ecount = 0;
    bit mtick = 1'b0;
    bit mp1 = 1'b0, mp2 = 1'b0;
    bit mdb [6];
    int mrun [6];
    int mdue [6];

    time_keeper_core #(.CLK_HZ(CLK_HZ), .DEB_CYCLES(DEB)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .operator(operator),
        .hour_bcd(hour_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
        .sec_tick(sec_tick), .edit_active(edit_active)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int wrap(input int v, input int d, input int modulus);
        return (v + d + modulus) % modulus;
    endfunction

    // Model: a press is accepted once the raw level has differed from the accepted
    // level for DEB consecutive samples; it lands 4 edges later (2 sync + strobe + update)
    // and only counts if the mode seen through the 2-stage delay is edit.
    initial begin : model
        bit msync;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mh = 0; mm = 0; ms = 0; mpc = 0; ecount = 0;
                mtick = 1'b0; mp1 = 1'b0; mp2 = 1'b0;
                for (int i = 0; i < 6; i++) begin
                    mdb[i] = 1'b1; mrun[i] = 0; mdue[i] = -1;
                end
            end else begin
                ecount++;
                msync = mp2;
                mtick = 1'b0;
                if (!msync) begin
                    if (mpc == CLK_HZ - 1) begin
                        mpc = 0;
                        mtick = 1'b1;
                        ms++;
                        if (ms == 60) begin
                            ms = 0; mm++;
                            if (mm == 60) begin
                                mm = 0; mh = (mh + 1) % 24;
                            end
                        end
                    end else begin
                        mpc++;
                    end
                end else begin
                    mpc = 0;
                    ms = wrap(ms, int'(mdue[0] == ecount) - int'(mdue[1] == ecount), 60);
                    mm = wrap(mm, int'(mdue[2] == ecount) - int'(mdue[3] == ecount), 60);
                    mh = wrap(mh, int'(mdue[4] == ecount) - int'(mdue[5] == ecount), 24);
                end
                for (int i = 0; i < 6; i++) begin
                    if (operator[i] != mdb[i]) begin
                        mrun[i]++;
                        if (mrun[i] == DEB) begin
                            mdb[i] = operator[i];
                            mrun[i] = 0;
                            if (!operator[i]) mdue[i] = ecount + 4;
                        end
                    end else begin
                        mrun[i] = 0;
                    end
                end
                mp2 = mp1;
                mp1 = mode;
            end
        end
    end

    // Every-cycle comparison against the model.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check_eq("hour", hour_bcd, bcd(mh));
                check_eq("min", min_bcd, bcd(mm));
                check_eq("sec", sec_bcd, bcd(ms));
                check_eq("tick", sec_tick, mtick);
                check_eq("edit", edit_active, mp2);
            end
            if (sec_tick) tick_cnt++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic press(input logic [5:0] mask, input int len);
        operator = ~mask;
        cyc(len);
        operator = 6'h3f;
        cyc(12);
    endtask

    task automatic set_time(input int h, input int m, input int s);
        logic [5:0] mask;
        int guard;
        guard = 0;
        while ((mh != h || mm != m || ms != s) && guard < 80) begin
            mask = 6'h00;
            if (ms != s) mask |= (((s - ms + 60) % 60) <= 30) ? 6'h01 : 6'h02;
            if (mm != m) mask |= (((m - mm + 60) % 60) <= 30) ? 6'h04 : 6'h08;
            if (mh != h) mask |= (((h - mh + 24) % 24) <= 12) ? 6'h10 : 6'h20;
            press(mask, 4);
            guard++;
        end
        check_eq("set_time", {8'h00, hour_bcd, min_bcd, sec_bcd}, {8'h00, bcd(h), bcd(m), bcd(s)});
    endtask

    initial begin : stim
        int t0;
        int len;
        logic [5:0] mask;

        // 1: reset and free run
        cyc(2);
        check_eq("rst_time", {8'h00, hour_bcd, min_bcd, sec_bcd}, 32'h0);
        check_eq("rst_tick", sec_tick, 1'b0);
        check_eq("rst_edit", edit_active, 1'b0);
        rst_n = 1'b1;
        t0 = tick_cnt;
        cyc(10);
        check_eq("run10_ticks", tick_cnt - t0, 1);
        check_eq("run10_sec", sec_bcd, 8'h01);
        check_eq("run10_hrmin", {hour_bcd, min_bcd}, 16'h0000);
        cyc(590);
        check_eq("run600", {8'h00, hour_bcd, min_bcd, sec_bcd}, 32'h00000100);

        // 2: full carry chain from 23:59:59
        mode = 1'b1;
        cyc(4);
        set_time(23, 59, 59);
        mode = 1'b0;
        t0 = tick_cnt;
        cyc(13);
        check_eq("wrap_ticks", tick_cnt - t0, 1);
        check_eq("wrap_time", {8'h00, hour_bcd, min_bcd, sec_bcd}, 32'h0);

        // 3: decrement borrows within field only, 60 minute steps return to start
        mode = 1'b1;
        cyc(4);
        check_eq("edit_frozen", {8'h00, hour_bcd, min_bcd, sec_bcd}, 32'h0);
        press(6'h02, 4);
        check_eq("sec_dec", {min_bcd, sec_bcd}, 16'h0059);
        press(6'h20, 4);
        check_eq("hr_dec", hour_bcd, 8'h23);
        for (int i = 0; i < 60; i++) press(6'h04, 4);
        check_eq("min60", {hour_bcd, min_bcd}, 16'h2300);

        // 4: bounce rejection, wrap without carry, no auto-repeat
        press(6'h01, 2);
        check_eq("bounce", sec_bcd, 8'h59);
        press(6'h01, 5);
        check_eq("sec_wrap", {min_bcd, sec_bcd}, 16'h0000);
        press(6'h01, 100);
        check_eq("hold", sec_bcd, 8'h01);

        // 5: simultaneous requests and run-mode discard
        press(6'h03, 4);
        check_eq("plus_minus", sec_bcd, 8'h01);
        press(6'h05, 4);
        check_eq("two_fields", {min_bcd, sec_bcd}, 16'h0102);
        mode = 1'b0;
        t0 = tick_cnt;
        cyc(3);
        press(6'h01, 4);
        check_eq("run_discard", sec_bcd, bcd(2 + tick_cnt - t0));

        // 6: asynchronous reset with a button held
        mode = 1'b1;
        cyc(4);
        set_time(12, 34, 56);
        mode = 1'b0;
        operator = 6'h3e;
        cyc(2);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_time", {8'h00, hour_bcd, min_bcd, sec_bcd}, 32'h0);
        check_eq("async_tick", sec_tick, 1'b0);
        cyc(2);
        rst_n = 1'b1;
        cyc(20);
        check_eq("held_after_rst", {8'h00, hour_bcd, min_bcd, sec_bcd}, 32'h00000002);
        mode = 1'b1;
        cyc(6);
        operator = 6'h3f;
        cyc(10);
        check_eq("release_quiet", sec_bcd, 8'h02);
        press(6'h01, 4);
        check_eq("repress", sec_bcd, 8'h03);

        // Randomised traffic against the model
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 5) == 0) mode = ~mode;
            mask = 6'($urandom) & 6'($urandom);
            operator = ~mask;
            len = $urandom_range(1, 8);
            cyc(len);
        end
        operator = 6'h3f;
        cyc(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
